libhdl_dwidth_down: RTL and testbench



---
 rtl/libhdl_dwidth_down_pkg.sv | 9 +
 rtl/libhdl_dwidth_down.sv | 99 +++++++++
 tb/tb_libhdl_dwidth_down.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/libhdl_dwidth_down_pkg.sv
// Shared types for the width down-converter: holding-register occupancy state.
package libhdl_dwidth_down_pkg;

  typedef enum logic {
    StEmpty = 1'b0,
    StShift = 1'b1
  } dwd_state_e;

endpackage

// File: rtl/libhdl_dwidth_down.sv
// Width down-converter: accepts one IN_LEN word per handshake and emits it as
// IN_LEN/OUT_LEN narrower beats, carrying the packet-end flag onto the final beat.
module libhdl_dwidth_down
  import libhdl_dwidth_down_pkg::*;
#(
  parameter int unsigned IN_LEN    = 32,
  parameter int unsigned OUT_LEN   = 8,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  output logic               o_irdy,
  input  logic               i_ivld,
  input  logic [IN_LEN-1:0]  i_idat,
  input  logic               i_ilast,
  input  logic               i_ordy,
  output logic               o_ovld,
  output logic [OUT_LEN-1:0] o_odat,
  output logic               o_olast,
  output logic               o_busy
);

  localparam int unsigned RATIO   = IN_LEN / OUT_LEN;
  localparam int unsigned CNT_LEN = $clog2(RATIO);
  localparam logic [CNT_LEN-1:0] CntMax = CNT_LEN'(RATIO - 1);

`ifdef LIBHDL_ASSERT
  if ((IN_LEN % OUT_LEN) != 0 || RATIO < 2) begin : g_param_err
    $error("libhdl_dwidth_down: IN_LEN must be a multiple of OUT_LEN with ratio >= 2");
  end
`endif

  dwd_state_e         state_q, state_d;
  logic [IN_LEN-1:0]  sreg_q, sreg_d;
  logic [CNT_LEN-1:0] cnt_q, cnt_d;
  logic               lreg_q, lreg_d;

  logic full, ohs, ihs, last_beat;

  assign full      = (state_q == StShift);
  assign last_beat = (cnt_q == CntMax);
  assign ohs       = full & i_ordy;
  // Accept the next word in the same cycle the final beat leaves: no bubble.
  assign o_irdy    = i_rst_n & (~full | (ohs & last_beat));
  assign ihs       = o_irdy & i_ivld;

  assign o_ovld  = full;
  assign o_busy  = full;
  assign o_olast = full & lreg_q & last_beat;

  always_comb begin
    o_odat = '0;
    if (MSB_FIRST) begin
      o_odat = sreg_q[IN_LEN-1 -: OUT_LEN];
    end else begin
      o_odat = sreg_q[OUT_LEN-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    lreg_d  = lreg_q;
    if (ihs) begin
      state_d = StShift;
      sreg_d  = i_idat;
      lreg_d  = i_ilast;
      cnt_d   = '0;
    end else if (ohs) begin
      if (last_beat) begin
        state_d = StEmpty;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
        if (MSB_FIRST) begin
          sreg_d = sreg_q << OUT_LEN;
        end else begin
          sreg_d = sreg_q >> OUT_LEN;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StEmpty;
      sreg_q  <= '0;
      cnt_q   <= '0;
      lreg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      lreg_q  <= lreg_d;
    end
  end

endmodule

// File: tb/tb_libhdl_dwidth_down.sv
// Directed bench for libhdl_dwidth_down: LSB-first instance plus an MSB-first instance.
module tb_libhdl_dwidth_down;

  logic        clk;
  logic        rst_n;
  logic        irdy, ivld, ilast, ordy, ovld, olast, busy;
  logic [31:0] idat;
  logic [7:0]  odat;
  logic        m_irdy, m_ivld, m_ordy, m_ovld, m_olast, m_busy;
  logic [31:0] m_idat;
  logic [7:0]  m_odat;

  int pass_cnt = 0;
  int total    = 0;

  libhdl_dwidth_down #(.IN_LEN(32), .OUT_LEN(8), .MSB_FIRST(1'b0)) u_lsb (
    .i_clk(clk), .i_rst_n(rst_n), .o_irdy(irdy), .i_ivld(ivld), .i_idat(idat),
    .i_ilast(ilast), .i_ordy(ordy), .o_ovld(ovld), .o_odat(odat), .o_olast(olast),
    .o_busy(busy)
  );

  libhdl_dwidth_down #(.IN_LEN(32), .OUT_LEN(8), .MSB_FIRST(1'b1)) u_msb (
    .i_clk(clk), .i_rst_n(rst_n), .o_irdy(m_irdy), .i_ivld(m_ivld), .i_idat(m_idat),
    .i_ilast(1'b0), .i_ordy(m_ordy), .o_ovld(m_ovld), .o_odat(m_odat), .o_olast(m_olast),
    .o_busy(m_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ivld = 1'b1; idat = 32'hFFFF_FFFF; ilast = 1'b1; ordy = 1'b1;
    m_ivld = 1'b0; m_idat = '0; m_ordy = 1'b1;
    step();
    step();
    total++; if (ovld !== 1'b0) $display("FAIL reset_ovld got=%b exp=0", ovld); else pass_cnt++;
    total++; if (odat !== 8'h00) $display("FAIL reset_odat got=%h exp=00", odat); else pass_cnt++;
    total++; if (olast !== 1'b0) $display("FAIL reset_olast got=%b exp=0", olast); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
    total++; if (irdy !== 1'b0) $display("FAIL reset_irdy got=%b exp=0", irdy); else pass_cnt++;
    ivld = 1'b0; ilast = 1'b0; idat = '0;
    rst_n = 1'b1;
    #1;
    total++; if (irdy !== 1'b1) $display("FAIL post_reset_irdy got=%b exp=1", irdy); else pass_cnt++;
    step();
    total++; if (ovld !== 1'b0) $display("FAIL no_capture_in_reset got=%b exp=0", ovld);
    else pass_cnt++;
  endtask

  task automatic test_single_word();
    logic [7:0] exp_b [4];
    exp_b = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    ivld = 1'b1; idat = 32'hA1B2_C3D4; ordy = 1'b1;
    #1;
    total++; if (irdy !== 1'b1) $display("FAIL single_irdy_idle got=%b exp=1", irdy); else pass_cnt++;
    step();
    ivld = 1'b0; idat = 32'h5555_5555;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (ovld !== 1'b1 || odat !== exp_b[k])
        $display("FAIL single_beat%0d got=%b/%h exp=1/%h", k, ovld, odat, exp_b[k]);
      else pass_cnt++;
      total++; if (irdy !== (k == 3))
        $display("FAIL single_irdy%0d got=%b exp=%b", k, irdy, (k == 3));
      else pass_cnt++;
      step();
    end
    total++; if (busy !== 1'b0 || ovld !== 1'b0)
      $display("FAIL single_done got busy=%b ovld=%b exp 0/0", busy, ovld);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3];
    words = '{32'h0302_0100, 32'h0706_0504, 32'h0B0A_0908};
    ivld = 1'b1; idat = words[0]; ordy = 1'b1;
    step();
    idat = words[1];
    for (int b = 0; b < 12; b++) begin
      #1;
      total++; if (ovld !== 1'b1 || odat !== 8'(b))
        $display("FAIL b2b_beat%0d got=%b/%h exp=1/%h", b, ovld, odat, 8'(b));
      else pass_cnt++;
      total++; if (irdy !== ((b % 4) == 3))
        $display("FAIL b2b_irdy%0d got=%b exp=%b", b, irdy, ((b % 4) == 3));
      else pass_cnt++;
      step();
      if (b == 3) idat = words[2];
      if (b == 7) ivld = 1'b0;
    end
    total++; if (ovld !== 1'b0) $display("FAIL b2b_drain got=%b exp=0", ovld); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    ivld = 1'b1; idat = 32'h1122_3344; ordy = 1'b1;
    step();
    ivld = 1'b1; idat = 32'hFFFF_FFFF;
    #1;
    total++; if (odat !== 8'h44) $display("FAIL bp_beat1 got=%h exp=44", odat); else pass_cnt++;
    step();
    ordy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++; if (ovld !== 1'b1 || odat !== 8'h33)
        $display("FAIL bp_hold%0d got=%b/%h exp=1/33", c, ovld, odat);
      else pass_cnt++;
      total++; if (irdy !== 1'b0) $display("FAIL bp_irdy%0d got=%b exp=0", c, irdy);
      else pass_cnt++;
      step();
    end
    ordy = 1'b1; ivld = 1'b0;
    #1;
    total++; if (odat !== 8'h33) $display("FAIL bp_resume33 got=%h exp=33", odat); else pass_cnt++;
    step();
    total++; if (odat !== 8'h22) $display("FAIL bp_resume22 got=%h exp=22", odat); else pass_cnt++;
    step();
    total++; if (odat !== 8'h11 || ovld !== 1'b1)
      $display("FAIL bp_resume11 got=%b/%h exp=1/11", ovld, odat);
    else pass_cnt++;
    step();
    total++; if (ovld !== 1'b0) $display("FAIL bp_no_capture got=%b exp=0", ovld); else pass_cnt++;
  endtask

  task automatic test_last_flag();
    logic [7:0] exp_b [8];
    exp_b = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    ivld = 1'b1; idat = 32'h1234_5678; ilast = 1'b0; ordy = 1'b1;
    step();
    idat = 32'hDEAD_BEEF; ilast = 1'b1;
    for (int b = 0; b < 8; b++) begin
      #1;
      total++; if (odat !== exp_b[b] || olast !== (b == 7))
        $display("FAIL last_beat%0d got=%h/%b exp=%h/%b", b, odat, olast, exp_b[b], (b == 7));
      else pass_cnt++;
      step();
      if (b == 3) begin ivld = 1'b0; ilast = 1'b0; idat = '0; end
    end
  endtask

  task automatic test_msb_first();
    logic [7:0] exp_b [4];
    exp_b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    m_ivld = 1'b1; m_idat = 32'hA1B2_C3D4; m_ordy = 1'b1;
    step();
    m_ivld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (m_ovld !== 1'b1 || m_odat !== exp_b[k])
        $display("FAIL msb_beat%0d got=%b/%h exp=1/%h", k, m_ovld, m_odat, exp_b[k]);
      else pass_cnt++;
      step();
    end
    total++; if (m_ovld !== 1'b0) $display("FAIL msb_done got=%b exp=0", m_ovld); else pass_cnt++;
  endtask

  task automatic test_reset_midword();
    logic [7:0] exp_b [4];
    exp_b = '{8'h04, 8'h03, 8'h02, 8'h01};
    ivld = 1'b1; idat = 32'hA1B2_C3D4; ordy = 1'b1;
    step();
    ivld = 1'b0;
    step();
    step();
    #1;
    total++; if (odat !== 8'hB2) $display("FAIL rst_pre got=%h exp=b2", odat); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total++; if (ovld !== 1'b0 || irdy !== 1'b0 || busy !== 1'b0)
      $display("FAIL rst_async got ovld=%b irdy=%b busy=%b exp 0/0/0", ovld, irdy, busy);
    else pass_cnt++;
    step();
    rst_n = 1'b1;
    #1;
    total++; if (irdy !== 1'b1 || ovld !== 1'b0)
      $display("FAIL rst_release got irdy=%b ovld=%b exp 1/0", irdy, ovld);
    else pass_cnt++;
    for (int c = 0; c < 3; c++) begin
      step();
      total++; if (ovld !== 1'b0) $display("FAIL rst_stale%0d got=%b exp=0", c, ovld);
      else pass_cnt++;
    end
    ivld = 1'b1; idat = 32'h0102_0304;
    step();
    ivld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (ovld !== 1'b1 || odat !== exp_b[k])
        $display("FAIL rst_next%0d got=%b/%h exp=1/%h", k, ovld, odat, exp_b[k]);
      else pass_cnt++;
      step();
    end
    total++; if (ovld !== 1'b0) $display("FAIL rst_next_done got=%b exp=0", ovld); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_last_flag();
    test_msb_first();
    test_reset_midword();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
